// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared WIDTH-bit register.
// Optional write counter output enabled by defining REG_WRITE_ARBITER_WR_COUNT_EN.
module reg_write_arbiter #(
  parameter int                NREQ      = 4,
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [WIDTH-1:0]          q,
  output logic                      busy,
`ifdef REG_WRITE_ARBITER_WR_COUNT_EN
  output logic [$clog2(NREQ)-1:0]   last_owner,
  output logic [7:0]                wr_count
`else
  output logic [$clog2(NREQ)-1:0]   last_owner
`endif
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    winner_q, winner_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [PW-1:0]    owner_q, owner_d;

  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  logic [PW:0]      cand;

  logic [WIDTH-1:0] slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // First set request at or after ptr, wrapping; cand never exceeds NREQ-1 after the wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(j);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!pick_found && req[cand[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    gnt_d    = '0;
    done_d   = '0;
    data_d   = data_q;
    owner_d  = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d         = ST_GRANT;
          winner_d        = pick_idx;
          gnt_d[pick_idx] = 1'b1;
        end
      end
      ST_GRANT: begin
        // Commit is unconditional: a dropped req during GRANT does not abort.
        state_d          = ST_DONE;
        data_d           = slice[winner_q];
        done_d[winner_q] = 1'b1;
        owner_d          = winner_q;
        ptr_d            = (winner_q == PW'(NREQ-1)) ? '0 : winner_q + PW'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      data_q   <= RESET_VAL;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      data_q   <= data_d;
      owner_q  <= owner_d;
    end
  end

`ifdef REG_WRITE_ARBITER_WR_COUNT_EN
  logic [7:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (state_q == ST_DONE) begin
      wr_count_d = wr_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`endif

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign q          = data_q;
  assign busy       = (state_q != ST_IDLE);
  assign last_owner = owner_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (NREQ=4, WIDTH=4, RESET_VAL=0).
module tb_reg_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  q;
  logic        busy;
  logic [1:0]  last_owner;
`ifdef REG_WRITE_ARBITER_WR_COUNT_EN
  logic [7:0]  wr_count;
`endif

  int checks   = 0;
  int failures = 0;

  reg_write_arbiter #(
    .NREQ(4),
    .WIDTH(4),
    .RESET_VAL(4'b0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .wdata(wdata),
    .gnt(gnt),
    .done(done),
    .q(q),
    .busy(busy),
`ifdef REG_WRITE_ARBITER_WR_COUNT_EN
    .last_owner(last_owner),
    .wr_count(wr_count)
`else
    .last_owner(last_owner)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and check the gnt/done exclusivity invariant.
  task automatic step();
    @(negedge clk);
    chk("gnt_done_excl", 32'(((|gnt) && (|done)) ? 1 : 0), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    wdata = 16'h0003;

    // Test 1: reset held for 2 cycles with all requests asserted
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_owner", 32'(last_owner), 32'h0);
    end
    reset = 1'b0;
    step();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    step();
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_q", 32'(q), 32'h3);
    step();
    chk("t1_idle", 32'(busy), 32'h0);
    $display("txn t1 first grant after reset -> requester 0");

    // Test 2: single request from requester 1
    req   = 4'b0010;
    wdata = 16'h00A0;
    step();
    chk("t2_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    chk("t2_done", 32'(done), 32'h2);
    chk("t2_q", 32'(q), 32'hA);
    chk("t2_owner", 32'(last_owner), 32'h1);
    chk("t2_gnt0", 32'(gnt), 32'h0);
    step();
    chk("t2_busy", 32'(busy), 32'h0);
    chk("t2_done0", 32'(done), 32'h0);
    $display("txn t2 req=0010 data=A -> q=%h owner=%0d", q, last_owner);

    // Test 3: two simultaneous requests from a freshly reset pointer
    do_reset();
    req   = 4'b0101;
    wdata = 16'h0C05;
    step();
    chk("t3_gnt_a", 32'(gnt), 32'h1);
    step();
    chk("t3_done_a", 32'(done), 32'h1);
    chk("t3_q_a", 32'(q), 32'h5);
    step();
    chk("t3_idle", 32'(busy), 32'h0);
    step();
    chk("t3_gnt_b", 32'(gnt), 32'h4);
    req = 4'b0000;
    step();
    chk("t3_done_b", 32'(done), 32'h4);
    chk("t3_q_b", 32'(q), 32'hC);
    chk("t3_owner", 32'(last_owner), 32'h2);
    step();
    $display("txn t3 req=0101 -> q=%h", q);

    // Test 4: all four requesting continuously; rotation 0,1,2,3,0
    do_reset();
    req   = 4'b1111;
    wdata = 16'h4321;
    for (int r = 0; r < 5; r++) begin
      step();
      chk("t4_gnt", 32'(gnt), 32'h1 << (r % 4));
      step();
      chk("t4_done", 32'(done), 32'h1 << (r % 4));
      chk("t4_q", 32'(q), 32'((r % 4) + 1));
      chk("t4_owner", 32'(last_owner), 32'(r % 4));
      if (r == 4) req = 4'b0000;
      step();
      chk("t4_idle", 32'(busy), 32'h0);
      $display("txn t4 round=%0d q=%h owner=%0d", r, q, last_owner);
    end

    // Test 5: reset during GRANT of requester 3 writing 0111 (q holds 1 beforehand)
    req   = 4'b1000;
    wdata = 16'h7000;
    step();
    chk("t5_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    #1 reset = 1'b1;
    #1;
    chk("t5_async_gnt", 32'(gnt), 32'h0);
    chk("t5_async_q", 32'(q), 32'h0);
    chk("t5_async_busy", 32'(busy), 32'h0);
    step();
    chk("t5_no_done", 32'(done), 32'h0);
    chk("t5_q_held", 32'(q), 32'h0);
    reset = 1'b0;
    req   = 4'b1001;
    wdata = 16'h7009;
    step();
    chk("t5_gnt0", 32'(gnt), 32'h1);
    chk("t5_done0", 32'(done), 32'h0);
    req = 4'b0000;
    step();
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_q", 32'(q), 32'h9);
    step();
    $display("txn t5 reset mid-grant, then req=1001 -> q=%h", q);

`ifdef REG_WRITE_ARBITER_WR_COUNT_EN
    // Test 6: write counter
    do_reset();
    chk("t6_cnt_rst", 32'(wr_count), 32'h0);
    wdata = 16'h1111;
    for (int n = 0; n < 256; n++) begin
      req = 4'b0001;
      step();
      req = 4'b0000;
      step();
      step();
      if (n == 4) chk("t6_cnt5", 32'(wr_count), 32'd5);
    end
    chk("t6_cnt_wrap", 32'(wr_count), 32'd0);
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    step();
    chk("t6_cnt_one", 32'(wr_count), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_cnt_clr", 32'(wr_count), 32'd0);
    step();
    reset = 1'b0;
    $display("txn t6 write counter wrap and clear");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
